// File: rtl/csa_accum_ctrl_if.sv
// csa_accum_ctrl_if
//   Bundles the job-control, operand-input and result-output signals of the
//   carry-save accumulation controller.
//
//   Handshake rule for both streams: a transfer happens on a rising clk edge
//   where valid and ready are both high. valid never waits for ready, and a
//   source holds its data stable until the transfer happens.
//
//   Signals (direction seen from the controller, modport slave):
//     start     in   pulse that begins a job, sampled only while idle
//     op_count  in   operands in the job, sampled with start
//     in_valid  in   operand valid
//     in_data   in   operand, unsigned
//     in_ready  out  controller accepts an operand this cycle
//     out_valid out  result valid
//     out_data  out  resolved sum, unsigned
//     out_ready in   consumer accepts the result
//     busy      out  controller is not idle
//   modport master is the operand source / result consumer side.
interface csa_accum_ctrl_if #(
    parameter int W     = 8,
    parameter int CNT_W = 4,
    parameter int AW    = W + CNT_W
) ();
    logic             start;
    logic [CNT_W-1:0] op_count;
    logic             in_valid;
    logic [W-1:0]     in_data;
    logic             in_ready;
    logic             out_valid;
    logic [AW-1:0]    out_data;
    logic             out_ready;
    logic             busy;

    modport slave (
        input  start, op_count, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );

    modport master (
        output start, op_count, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/csa_accum_ctrl.sv
// csa_accum_ctrl
//   Folds a stream of W-bit unsigned operands into a redundant sum/carry
//   pair with one 3:2 compression per accepted operand, then performs a
//   single carry-propagate add and offers the AW-bit total to a consumer.
//
//   Ports:
//     clk        rising-edge system clock
//     rst_n      asynchronous active-low reset
//     bus        csa_accum_ctrl_if.slave (start/op_count, operand stream,
//                result stream, busy)
//     state_dbg  current FSM state encoding (IDLE=0, ACCUM=1, RESOLVE=2,
//                DONE=3)
module csa_accum_ctrl #(
    parameter int W     = 8,
    parameter int CNT_W = 4,
    parameter int AW    = W + CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    csa_accum_ctrl_if.slave     bus,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [AW-1:0]    sum_q, sum_n;
    logic [AW-1:0]    carry_q, carry_n;
    logic [CNT_W-1:0] count_q, count_n;
    logic [AW-1:0]    out_q, out_n;

    logic [AW-1:0]    x;
    logic [AW-1:0]    csa_sum;
    logic [AW-1:0]    csa_maj;

    // 3:2 compressor: the majority term moves one bit left to become the
    // new carry vector; its top bit falls off, which is harmless because the
    // true total always fits in AW bits.
    assign x       = AW'(bus.in_data);
    assign csa_sum = sum_q ^ carry_q ^ x;
    assign csa_maj = (sum_q & carry_q) | (sum_q & x) | (carry_q & x);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sum_q   <= '0;
            carry_q <= '0;
            count_q <= '0;
            out_q   <= '0;
        end else begin
            state   <= state_n;
            sum_q   <= sum_n;
            carry_q <= carry_n;
            count_q <= count_n;
            out_q   <= out_n;
        end
    end

    always_comb begin
        state_n = state;
        sum_n   = sum_q;
        carry_n = carry_q;
        count_n = count_q;
        out_n   = out_q;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    sum_n   = '0;
                    carry_n = '0;
                    count_n = bus.op_count;
                    // An empty job still goes through RESOLVE so it reports
                    // a zero total with the same latency as any other job.
                    state_n = (bus.op_count != '0) ? ACCUM : RESOLVE;
                end
            end
            ACCUM: begin
                if (bus.in_valid) begin
                    sum_n   = csa_sum;
                    carry_n = {csa_maj[AW-2:0], 1'b0};
                    count_n = count_q - 1'b1;
                    if (count_q == CNT_W'(1)) begin
                        state_n = RESOLVE;
                    end
                end
            end
            RESOLVE: begin
                out_n   = sum_q + carry_q;
                state_n = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = out_q;
    assign bus.busy      = (state != IDLE);
    assign state_dbg     = state;

endmodule

// File: tb/tb_csa_accum_ctrl.sv
module tb_csa_accum_ctrl;

    localparam int W     = 8;
    localparam int CNT_W = 4;
    localparam int AW    = W + CNT_W;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCUM   = 2'd1;
    localparam logic [1:0] ST_RESOLVE = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    csa_accum_ctrl_if #(.W(W), .CNT_W(CNT_W), .AW(AW)) bus ();
    logic [1:0] state_dbg;

    csa_accum_ctrl #(.W(W), .CNT_W(CNT_W), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] model_sum;
    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int cnt);
        for (int i = 0; i < 50; i++) begin
            if (!bus.busy) break;
            tick();
        end
        check("idle_before_start", 32'(bus.busy), 32'd0);
        bus.start    = 1'b1;
        bus.op_count = CNT_W'(cnt);
        tick();
        bus.start    = 1'b0;
        model_sum    = '0;
    endtask

    task automatic send_op(input logic [W-1:0] d);
        bit got;
        got          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int i = 0; i < 50; i++) begin
            if (bus.in_ready) begin
                tick();
                got = 1'b1;
                break;
            end
            tick();
        end
        check("op_accepted", 32'(got), 32'd1);
        if (got) model_sum = model_sum + AW'(d);
    endtask

    // Called in the cycle right after the last handshake: the job's total
    // goes to the scoreboard, and the two-cycle result latency is checked.
    task automatic end_ops_and_check_latency();
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom_range(0, 255);
        exp_q.push_back(model_sum);
        check("lat_resolve_state", 32'(state_dbg), 32'(ST_RESOLVE));
        check("lat_no_valid_yet", 32'(bus.out_valid), 32'd0);
        check("lat_in_ready_low", 32'(bus.in_ready), 32'd0);
        tick();
        check("lat_valid_at_t2", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic collect(input int hold);
        logic [AW-1:0] e;
        for (int i = 0; i < 50; i++) begin
            if (bus.out_valid) break;
            tick();
        end
        check("out_valid_seen", 32'(bus.out_valid), 32'd1);
        check("exp_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("out_data", 32'(bus.out_data), 32'(e));
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_data", 32'(bus.out_data), 32'(e));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("valid_drops", 32'(bus.out_valid), 32'd0);
        check("idle_after_done", 32'(bus.busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cnt;
        bus.start     = 1'b0;
        bus.op_count  = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Power-on reset
        #23;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic job: 10 + 20 + 30
        start_job(3);
        check("basic_accum_state", 32'(state_dbg), 32'(ST_ACCUM));
        check("basic_in_ready", 32'(bus.in_ready), 32'd1);
        send_op(8'd10);
        send_op(8'd20);
        send_op(8'd30);
        end_ops_and_check_latency();
        check("basic_total_const", 32'(exp_q[0]), 32'h03C);
        collect(0);

        // Max job: 15 x 255 with a 2-cycle gap after operand 7
        start_job(15);
        for (int i = 0; i < 15; i++) begin
            send_op(8'd255);
            if (i == 6) begin
                bus.in_valid = 1'b0;
                for (int g = 0; g < 2; g++) begin
                    check("gap_in_ready", 32'(bus.in_ready), 32'd1);
                    tick();
                end
            end
        end
        end_ops_and_check_latency();
        check("max_total_const", 32'(exp_q[0]), 32'hEF1);
        collect(0);

        // Zero job
        start_job(0);
        exp_q.push_back('0);
        check("zero_in_ready", 32'(bus.in_ready), 32'd0);
        check("zero_no_valid_yet", 32'(bus.out_valid), 32'd0);
        tick();
        check("zero_valid_at_t2", 32'(bus.out_valid), 32'd1);
        collect(0);

        // Back-pressure: out_ready low for 5 cycles in DONE
        start_job(2);
        send_op(8'd100);
        send_op(8'd77);
        end_ops_and_check_latency();
        collect(5);

        // start pulse during ACCUM is ignored
        start_job(2);
        send_op(8'd1);
        bus.in_valid = 1'b0;
        bus.start    = 1'b1;
        bus.op_count = CNT_W'(9);
        tick();
        bus.start    = 1'b0;
        check("ignore_start_state", 32'(state_dbg), 32'(ST_ACCUM));
        send_op(8'd2);
        end_ops_and_check_latency();
        check("ignore_total_const", 32'(exp_q[0]), 32'd3);
        collect(0);

        // Abort mid-job with an asynchronous reset between clock edges
        start_job(4);
        send_op(8'd5);
        send_op(8'd6);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd9;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_reset_outputs("post_abort");

        start_job(2);
        send_op(8'd7);
        send_op(8'd8);
        end_ops_and_check_latency();
        check("after_abort_total_const", 32'(exp_q[0]), 32'd15);
        collect(0);

        // Randomised jobs with input gaps and output back-pressure
        for (int j = 0; j < 4; j++) begin
            cnt = $urandom_range(1, 15);
            start_job(cnt);
            for (int k = 0; k < cnt; k++) begin
                send_op(W'($urandom_range(0, 255)));
                if (k != cnt - 1 && $urandom_range(0, 2) == 0) begin
                    bus.in_valid = 1'b0;
                    repeat ($urandom_range(1, 2)) tick();
                end
            end
            end_ops_and_check_latency();
            collect($urandom_range(0, 3));
        end

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/csa_accum_ctrl.md
Name: csa_accum_ctrl

Overview:
- Sequencing controller for the carry-save adder datapath.
- Accepts a stream of operands over a valid/ready handshake and folds each one into a redundant sum/carry pair using a W-bit-extended 3:2 compression step, one operand per cycle.
- After the last operand, it performs a single carry-propagate resolve and presents the binary total on a valid/ready output.
- Sits between an operand source (e.g. a partial-product generator) and any consumer needing multi-operand sums.

Parameters:
- W, 8, operand width in bits.
- CNT_W, 4, width of the operand count; max operands per job N_MAX = 2^CNT_W - 1.
- AW, W+CNT_W, accumulator/result width; guarantees no overflow for N_MAX operands of value 2^W-1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  pulse: begin a job; sampled only in IDLE.
- op_count  input  CNT_W  number of operands in the job; sampled with start.
- in_valid  input  1  operand valid.
- in_data  input  W  operand, unsigned.
- in_ready  output  1  controller accepts operand this cycle.
- out_valid  output  1  result valid.
- out_data  output  AW  resolved sum, unsigned.
- out_ready  input  1  consumer accepts result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync deassert to clk):
  - state=IDLE; sum and carry registers = 0; count = 0.
  - in_ready=0, out_valid=0, out_data=0, busy=0.
- States:
  - IDLE:
    - start=1 with op_count>0 -> ACCUM; load count=op_count; clear sum and carry regs.
    - start=1 with op_count=0 -> RESOLVE; sum and carry cleared.
  - ACCUM:
    - in_ready=1. Handshake = in_valid & in_ready.
    - On handshake, per bit i: s'[i] = S[i]^C[i]^X[i]; c'[i+1] = maj(S[i],C[i],X[i]); c'[0] = 0. X is in_data zero-extended to AW. Bit AW of c' is discarded.
    - count decrements on each handshake; the handshake with count=1 -> RESOLVE.
    - No handshake -> hold all state; gaps in in_valid are legal.
  - RESOLVE (exactly 1 cycle):
    - in_ready=0; out_data <= (sum + carry) mod 2^AW -> DONE.
  - DONE:
    - out_valid=1; out_data held stable.
    - out_ready=1 -> IDLE, out_valid=0 next cycle.
    - out_ready low -> hold indefinitely.
- Latency:
  - Last handshake in cycle t -> out_valid=1 from cycle t+2.
  - op_count=0: start in cycle t -> out_valid=1 from cycle t+2, out_data=0.
- Throughput: 1 operand/cycle while in_valid stays high. The next start is accepted no earlier than the cycle after the DONE handshake.
- start outside IDLE is ignored; op_count is not re-sampled.
- in_data outside ACCUM is ignored (in_ready=0).
- Reset asserted mid-job aborts immediately: all registers return to reset values, no partial result is emitted, and the in-flight operand is dropped.
- Arithmetic is modular 2^AW. Within parameter limits this is exact, because the true sum is at most N_MAX*(2^W-1) < 2^AW.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-clock -> state IDLE, in_ready=0, out_valid=0, out_data=0, busy=0 immediately, without waiting for a clock edge.
- Basic job: start with op_count=3; operands 10, 20, 30 back-to-back -> out_valid two cycles after the third handshake; out_data=60 (0x03C).
- Max job: op_count=15, all operands 255, with in_valid deasserted for 2 cycles after operand 7 -> in_ready held high; out_data=3825 (0xEF1); no overflow.
- Zero job: start with op_count=0 -> no in_ready; out_valid=1 two cycles later with out_data=0.
- Back-pressure and ignore:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable throughout.
  - Pulse start during ACCUM -> count unchanged and result unaffected (operands 1, 2 -> 3).
- Abort: op_count=4; after 2 operands (5, 6) assert rst_n=0 -> outputs at reset values. Then a new job with op_count=2 and operands 7, 8 -> out_data=15, showing no residue from the aborted job.
